// File: rtl/rv_pkg.sv
// Shared core definitions: data widths, the canonical NOP encoding and the
// fetch stage state/entry types.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Decode-facing output register backed by a one-entry skid register, so a
// response that lands while decode is stalled is never lost.
module fetch_buf
    import rv_pkg::*;
(
    input  logic         clk,
    input  logic         areset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         out_valid,
    output fetch_entry_t out_entry,
    output logic         sk_valid
);

    fetch_entry_t out_q;
    fetch_entry_t sk_q;
    logic         xfer;

    assign xfer      = out_valid && pop;
    assign out_entry = out_q;

    // The controller never pushes while the skid is occupied, so a push
    // either lands in the output register or fills an empty skid.
    always_ff @(posedge clk) begin
        if (areset) begin
            out_valid <= 1'b0;
            out_q     <= '{instr: NOP_INSTR, pc: '0};
            sk_valid  <= 1'b0;
            sk_q      <= '{instr: NOP_INSTR, pc: '0};
        end else if (flush) begin
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
        end else if (push && (!out_valid || xfer)) begin
            out_valid <= 1'b1;
            out_q     <= push_entry;
        end else if (push) begin
            sk_valid  <= 1'b1;
            sk_q      <= push_entry;
        end else if (xfer) begin
            out_valid <= sk_valid;
            sk_valid  <= 1'b0;
            if (sk_valid) begin
                out_q <= sk_q;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, PC advance on
// accept or branch flush, and a skid-buffered valid/ready path to decode.
module fetch_unit
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            areset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_load,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);

    fetch_state_t    state;
    logic [XLEN-1:0] req_pc;
    logic            req_fire;
    logic            rsp_take;
    logic            out_free;
    logic            buf_valid;
    logic            sk_valid;
    fetch_entry_t    buf_entry;

    assign imem_req_valid = !areset && (state == ST_REQ) && !flush && !sk_valid;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_load        = !areset && (req_fire || flush);

    // Responses only count in WAIT; in DRAIN they are swallowed and in any
    // other state they are strays from an abandoned request.
    assign rsp_take = !areset && !flush && (state == ST_WAIT) && imem_rsp_valid;
    assign out_free = !buf_valid || id_ready;

    always_ff @(posedge clk) begin
        if (areset) begin
            state  <= ST_REQ;
            req_pc <= '0;
        end else if (flush) begin
            state <= (state == ST_WAIT && !imem_rsp_valid) ? ST_DRAIN : ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= out_free ? ST_REQ : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (buf_valid && id_ready) begin
                        state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .areset     (areset),
        .push       (rsp_take),
        .push_entry ('{instr: imem_rsp_data, pc: req_pc}),
        .pop        (id_ready),
        .flush      (flush),
        .out_valid  (buf_valid),
        .out_entry  (buf_entry),
        .sk_valid   (sk_valid)
    );

    assign if_valid = buf_valid;
    assign if_instr = buf_valid ? buf_entry.instr : NOP_INSTR;
    assign if_pc    = buf_entry.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the PC unit. It issues the current `pc` to instruction memory over a valid/ready request channel and waits for the response. It presents the fetched instruction and its PC to decode through a valid/ready output. It pulses `pc_load` to advance the PC unit exactly once per accepted fetch, or on a branch flush. One request is outstanding at most; a one-entry skid buffer absorbs decode back-pressure.

## Interface
- `XLEN`, 32, address and instruction width
- `NOP_INSTR`, 32'h0000_0013, value driven on `if_instr` when `if_valid`=0 (addi x0,x0,0)
- `clk`  in  1  clock; all state updates on rising edge
- `areset`  in  1  reset, synchronous, active-high
- `pc`  in  XLEN  current PC from the PC unit
- `pc_load`  out  1  load enable to the PC unit
- `flush`  in  1  taken branch from execute; PC unit loads the branch target this cycle
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  XLEN  fetch address, equal to `pc` while `imem_req_valid`
- `imem_rsp_valid`  in  1  response valid, one-cycle pulse per accepted request
- `imem_rsp_data`  in  XLEN  fetched instruction
- `if_valid`  out  1  instruction available to decode
- `if_instr`  out  XLEN  instruction
- `if_pc`  out  XLEN  PC of `if_instr`
- `id_ready`  in  1  decode accepts; transfer occurs when `if_valid && id_ready`

## Operation
- States: REQ, WAIT, DRAIN, HOLD. Internal registers: `req_pc`, output register (`if_valid/if_instr/if_pc`), skid register (`sk_valid/sk_instr/sk_pc`).
- REQ: `imem_req_valid = !flush && !sk_valid`.
  - On handshake: capture `req_pc <= pc`, assert `pc_load`, and go to WAIT.
  - Without a handshake, stay in REQ.
- WAIT: no request is issued. On `imem_rsp_valid`:
  - If the output register is empty or is being consumed this cycle, load it with (`imem_rsp_data`, `req_pc`) and go to REQ.
  - Otherwise, load the skid register and go to HOLD.
- HOLD: on a decode transfer, move skid to output, clear `sk_valid`, and go to REQ.
- DRAIN: discard the next `imem_rsp_valid` without writing anything, then go to REQ.
- `flush`, any state, has priority over all other events that cycle:
  - clear `if_valid` and `sk_valid`;
  - assert `pc_load`;
  - go to DRAIN if in WAIT with no response this cycle; otherwise go to REQ.
  - A response arriving in the flush cycle is dropped.
- `pc_load = (REQ handshake) || flush`. It is never asserted twice for one request.
- `if_instr` = `NOP_INSTR` whenever `if_valid`=0.
- Output register holds value while `if_valid && !id_ready`.

## Timing
- Reset (sync, `areset`=1 at an edge):
  - state = REQ;
  - `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc`=0;
  - `sk_valid`=0, `req_pc`=0;
  - `imem_req_valid` and `pc_load` forced 0 while `areset`=1.
  - Reset mid-WAIT abandons the request. A later stray `imem_rsp_valid` arriving in REQ is ignored.
- Request accepted in cycle N means `pc_load`=1 in cycle N, and the PC unit shows the new `pc` in N+1.
- Response in cycle M means `if_valid`=1 from cycle M+1.
- Zero-wait memory (response in N+1): peak throughput is one instruction per 2 cycles.
- `imem_rsp_valid` outside WAIT/DRAIN is ignored.

## Structure
- Shared package `rv_pkg`: `XLEN`, `NOP_INSTR`, the fetch state enum `fetch_state_t`.
- Sub-module `fetch_buf`: output register plus skid register, with push/pop/flush interface.
- FSM and request logic live in `fetch_unit`.

## Test plan
- Reset then zero-wait memory, `id_ready`=1, `pc` 0,4,8 → `if_pc` 0,4,8 with matching `if_instr`; `pc_load` one pulse per fetch; `if_valid` every other cycle.
- `imem_req_ready` low 3 cycles at `pc`=0x10 → `imem_addr` held at 0x10, no `pc_load` until accept, one instruction delivered.
- `id_ready`=0 for 5 cycles → output holds, second response goes to skid, no new request. Release → both delivered in order with no loss or duplicate.
- `flush` in WAIT at `pc`=0x20, response 2 cycles later → response dropped, `if_valid` stays 0, next request uses the new `pc` (branch target, e.g. 0x100).
- `flush` in the same cycle as `imem_rsp_valid` and with `if_valid`=1 → both squashed, `if_instr`=0x00000013, state REQ next cycle.
- `areset` asserted in WAIT, then stray `imem_rsp_valid` after release → ignored; first fetch after reset uses the current `pc`.
